par_serial_tx: RTL and testbench

Transmit-side parallel-to-serial converter for the PHY. It runs on the fastest PHY clock, clk16f, the same clock the clock generator divides to produce clk4f/clk2f/clkf. It accepts parallel words over a valid/ready handshake and shifts them out MSB first, one bit per cycle. After reset it sends a fixed number of idle (comma) words so the receiver can align, and it fills any gap in the input stream with idle words.

---
 rtl/par_serial_tx.sv | 114 +++++++++++
 tb/tb_par_serial_tx.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/par_serial_tx.sv
// Parallel-to-serial transmitter: MSB-first shift-out with idle-word sync preamble and gap fill.
// state | meaning:  SYNC | idle words only, counting the alignment preamble;  RUN | data words accepted on load edges
module par_serial_tx #(
    parameter int                DATA_W     = 8,
    parameter logic [DATA_W-1:0] IDLE_WORD  = 8'hBC,
    parameter int                SYNC_WORDS = 4
) (
    input  logic              clk16f,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              data_out,
    output logic              frame_start,
    output logic              active,
    output logic              sync_done
);

    localparam int BC_W = $clog2(DATA_W);
    localparam int SC_W = (SYNC_WORDS > 1) ? $clog2(SYNC_WORDS) : 1;
    localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(DATA_W - 1);
    localparam logic [SC_W-1:0] SYNC_LAST = SC_W'(SYNC_WORDS - 1);

    typedef enum logic {
        S_SYNC = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [BC_W-1:0]   r_bit_cnt;
    logic [SC_W-1:0]   r_sync_cnt;
    logic [DATA_W-1:0] r_shift;
    logic              r_data_out;
    logic              r_frame_start;
    logic              r_active;
    logic              r_sync_done;

    logic              w_load;
    logic              w_take_data;
    logic              w_sync_last;
    logic [DATA_W-1:0] w_word;

    assign w_load      = (r_bit_cnt == BIT_LAST);
    assign w_take_data = (r_state == S_RUN) && valid_in;
    assign w_sync_last = (r_sync_cnt == SYNC_LAST);
    assign w_word      = w_take_data ? data_in : IDLE_WORD;

    always_ff @(posedge clk16f) begin
        if (reset) begin
            r_state <= S_SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_SYNC:  if (w_load && w_sync_last) w_state_nxt = S_RUN;
            S_RUN:   w_state_nxt = S_RUN;
            default: w_state_nxt = S_SYNC;
        endcase
    end

    // Decoded from registers only so upstream never sees a path from valid_in.
    always_comb begin
        ready_out = 1'b0;
        if (r_state == S_RUN && w_load) begin
            ready_out = 1'b1;
        end
    end

    always_ff @(posedge clk16f) begin
        if (reset) begin
            r_bit_cnt     <= BIT_LAST;
            r_shift       <= '0;
            r_data_out    <= 1'b0;
            r_frame_start <= 1'b0;
            r_active      <= 1'b0;
        end else if (w_load) begin
            r_bit_cnt     <= '0;
            r_shift       <= {w_word[DATA_W-2:0], 1'b0};
            r_data_out    <= w_word[DATA_W-1];
            r_frame_start <= 1'b1;
            r_active      <= w_take_data;
        end else begin
            r_bit_cnt     <= r_bit_cnt + 1'b1;
            r_shift       <= {r_shift[DATA_W-2:0], 1'b0};
            r_data_out    <= r_shift[DATA_W-1];
            r_frame_start <= 1'b0;
        end
    end

    // Sync counter only advances on idle loads in SYNC; it is frozen once RUN is reached.
    always_ff @(posedge clk16f) begin
        if (reset) begin
            r_sync_cnt  <= '0;
            r_sync_done <= 1'b0;
        end else if (r_state == S_SYNC && w_load) begin
            if (w_sync_last) begin
                r_sync_done <= 1'b1;
            end else begin
                r_sync_cnt <= r_sync_cnt + 1'b1;
            end
        end
    end

    assign data_out    = r_data_out;
    assign frame_start = r_frame_start;
    assign active      = r_active;
    assign sync_done   = r_sync_done;

endmodule

// File: tb/tb_par_serial_tx.sv
// Scoreboard bench for par_serial_tx: per-edge arithmetic model of the serial stream against a queue of issued words.
module tb_par_serial_tx;

    localparam int          DW   = 8;
    localparam int          SW   = 4;
    localparam logic [7:0]  IDLE = 8'hBC;

    logic       clk16f   = 1'b0;
    logic       reset    = 1'b1;
    logic       valid_in = 1'b0;
    logic [7:0] data_in  = 8'h00;
    logic       ready_out;
    logic       data_out;
    logic       frame_start;
    logic       active;
    logic       sync_done;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    par_serial_tx #(.DATA_W(DW), .IDLE_WORD(IDLE), .SYNC_WORDS(SW)) dut (
        .clk16f     (clk16f),
        .reset      (reset),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .data_out   (data_out),
        .frame_start(frame_start),
        .active     (active),
        .sync_done  (sync_done)
    );

    always #5 clk16f = ~clk16f;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp, input int edge_no);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s after edge %0d: got %0h, want %0h (t=%0t)", nm, edge_no, act, exp, $time);
        end
    endtask

    // Monitor: edge e counts posedges since reset went low; every output is a function of e and the words accepted.
    initial begin
        int         e      = 0;
        bit         rdy_m  = 1'b0;
        logic [7:0] w      = IDLE;
        bit         w_data = 1'b0;
        bit         rst_s;
        bit         v_s;
        int         k;
        forever begin
            @(posedge clk16f);
            rst_s = reset;
            v_s   = valid_in;
            @(negedge clk16f);
            if (rst_s) begin
                e     = 0;
                rdy_m = 1'b0;
                check("rst_data_out",    data_out,    0, e);
                check("rst_frame_start", frame_start, 0, e);
                check("rst_active",      active,      0, e);
                check("rst_sync_done",   sync_done,   0, e);
                check("rst_ready_out",   ready_out,   0, e);
            end else begin
                e++;
                k = (e - 1) % DW;
                if (k == 0) begin
                    if (rdy_m && v_s) begin
                        n_vec++;
                        if (exp_q.size() == 0) begin
                            n_err++;
                            $display("FAIL accept after edge %0d: got word with no issued data, want none", e);
                            w = IDLE;
                        end else begin
                            w = exp_q.pop_front();
                        end
                        w_data = 1'b1;
                    end else begin
                        w      = IDLE;
                        w_data = 1'b0;
                    end
                end
                check("data_out",    data_out,    w[DW-1-k],                e);
                check("frame_start", frame_start, (k == 0),                 e);
                check("active",      active,      w_data,                   e);
                check("sync_done",   sync_done,   (e >= 1 + (SW-1)*DW),     e);
                rdy_m = (e % DW == 0) && (e >= 1 + (SW-1)*DW);
                check("ready_out",   ready_out,   rdy_m,                    e);
            end
        end
    end

    task automatic tick();
        @(posedge clk16f);
        #1;
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        repeat (n) tick();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Hold the word until the handshake; optionally pulse reset rst_at cycles into the wait.
    task automatic send(input logic [7:0] w, input int rst_at);
        bit hs = 1'b0;
        exp_q.push_back(w);
        valid_in = 1'b1;
        data_in  = w;
        for (int k = 0; k < 300 && !hs; k++) begin
            if (k == rst_at) reset = 1'b1;
            @(negedge clk16f);
            hs = ready_out && valid_in && !reset;
            @(posedge clk16f);
            #1;
            reset = 1'b0;
        end
        valid_in = 1'b0;
        data_in  = 8'($urandom);
        if (!hs) begin
            n_vec++;
            n_err++;
            $display("FAIL handshake timeout for word %0h: got no ready_out, want transfer", w);
            void'(exp_q.pop_back());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;
        repeat (3) tick();
        reset = 1'b0;
        idle(64);

        pulse_reset();
        idle(29);
        send(8'hA5, -1);
        send(8'h00, -1);
        send(8'hFF, -1);
        send(8'h3C, -1);
        send(8'h11, -1);
        idle(DW);
        send(8'h22, -1);
        send(8'h77, -1);
        idle(3);
        pulse_reset();
        idle(4);
        send(8'h5A, -1);
        send(8'hC3, 12);

        repeat (40) begin
            r = $urandom_range(0, 9);
            if (r < 6)       send(8'($urandom), -1);
            else if (r == 6) send(8'($urandom), $urandom_range(0, 20));
            else if (r < 9)  idle($urandom_range(1, 20));
            else begin
                pulse_reset();
                idle($urandom_range(0, 12));
            end
        end

        idle(2*DW);
        check("queue_drained", exp_q.size(), 0, -1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
